dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/arm_pkg.sv | 17 +
 rtl/dmem_ram.sv | 24 ++
 rtl/dmem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the memory-stage data path
package arm_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } memState_t;

   function automatic logic isMisaligned(input logic [1:0] byteOffset);
      return byteOffset != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word-addressed data storage, synchronous write, combinational read
module dmem_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   // Contents deliberately survive reset.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder for the memory stage
module dmem_responder
   import arm_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemReqM,
   input  logic             MemWriteM,
   input  logic [WIDTH-1:0] AddrM,
   input  logic [WIDTH-1:0] WriteDataM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic             ReadValidM,
   output logic             StallM,
   output logic             AlignErrM
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CAP_W = IDX_W + 2;

   memState_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CAP_W-1:0] capAddr;
   logic [CAP_W-1:0] curAddr;
   logic [WIDTH-1:0] capData;
   logic [WIDTH-1:0] ramRdata;
   logic             capWrite;
   logic             curWrite;
   logic             curMis;
   logic             enterDone;
   logic             ramWe;
   logic             unusedAddrBits;

   // Address bits above the word index only alias the same storage.
   assign unusedAddrBits = ^AddrM[WIDTH-1:CAP_W];

   // With LATENCY=1 the access finishes on the accepting edge, before capture.
   assign curAddr  = (state == IDLE) ? AddrM[CAP_W-1:0] : capAddr;
   assign curWrite = (state == IDLE) ? MemWriteM : capWrite;
   assign curMis   = isMisaligned(curAddr[1:0]);

   assign enterDone = ((state == IDLE) && MemReqM && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == CNT_W'(1)));

   assign ramWe  = (state == DONE) && capWrite && !isMisaligned(capAddr[1:0]);
   assign StallM = reset && (((state == IDLE) && MemReqM) || (state == BUSY));

   dmem_ram #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) uRam (
      .clk  (clk),
      .we   (ramWe),
      .addr (curAddr[CAP_W-1:2]),
      .wdata(capData),
      .rdata(ramRdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         capAddr    <= '0;
         capData    <= '0;
         capWrite   <= 1'b0;
         ReadDataM  <= '0;
         ReadValidM <= 1'b0;
         AlignErrM  <= 1'b0;
      end else begin
         ReadValidM <= 1'b0;
         AlignErrM  <= 1'b0;
         if (enterDone) begin
            ReadValidM <= 1'b1;
            AlignErrM  <= curMis;
            if (!curWrite) begin
               ReadDataM <= curMis ? '0 : ramRdata;
            end
         end
         case (state)
            IDLE: begin
               if (MemReqM) begin
                  capAddr  <= AddrM[CAP_W-1:0];
                  capData  <= WriteDataM;
                  capWrite <= MemWriteM;
                  cnt      <= CNT_W'(LATENCY - 1);
                  state    <= (LATENCY == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
